rtc_access_sched: RTL and testbench
===================================

Name: rtc_access_sched

Overview:
- Scheduler sitting between the clock/date/timer edit blocks and the single RTC bus master.
- Serialises three write requesters and a periodic read poller onto one byte-wide register bus.
- Runs each request as a multi-byte burst, so a time, date or timer value moves as one unit.
- After each read poll, publishes fresh BCD time/date words for the display and edit blocks.

Parameters:
- POLL_DIV, 100000, clk cycles between periodic read polls (≥2).
- TIME_BASE, 8'h21, RTC address of seconds; minutes at +1, hours at +2.
- DATE_BASE, 8'h24, RTC address of day; month at +1, year at +2.
- TIMER_BASE, 8'h41, RTC address of timer seconds; +1 minutes, +2 hours.
- TIMEOUT, 255, bus watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  when low, no new burst is granted; a burst in progress completes.
- wr_time_req  in  1  level request to write time.
- wr_time_data  in  24  {H,M,S} BCD.
- wr_time_ack  out  1  1-cycle pulse, time burst done.
- wr_date_req  in  1  level request to write date.
- wr_date_data  in  24  {Y,Mo,D} BCD.
- wr_date_ack  out  1  1-cycle pulse.
- wr_timer_req  in  1  level request to write timer.
- wr_timer_data  in  24  {H,M,S} BCD.
- wr_timer_ack  out  1  1-cycle pulse.
- bus_req  out  1  transaction request, held until bus_done.
- bus_wr  out  1  1 = write, 0 = read.
- bus_addr  out  8  register address.
- bus_wdata  out  8  write byte.
- bus_done  in  1  1-cycle completion pulse from the bus master.
- bus_rdata  in  8  read byte, valid with bus_done.
- time_rd  out  24  last polled {H,M,S}.
- date_rd  out  24  last polled {Y,Mo,D}.
- rd_valid  out  1  1-cycle pulse when time_rd/date_rd update.
- busy  out  1  high in any state except IDLE.
- bus_err  out  1  1-cycle pulse on watchdog abort (optional feature).

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, state IDLE, poll counter 0, last_was_write 0. poll_pend resets to 1, so the first poll follows reset immediately.
- Poll counter: counts 0..POLL_DIV-1 and wraps. At wrap, poll_pend is set. A poll burst clears poll_pend on grant. A tick arriving during any burst stays pending.
- Every completed time or date write also sets poll_pend, so a read-back follows.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitration runs only when en=1.
  - If poll_pend is set and last_was_write=1, grant the poll.
  - Otherwise grant in fixed priority: time > date > timer > poll.
  - On grant: latch the 24-bit data into a shadow register, set beat=0, set beats to 3 (write) or 6 (read), go to ISSUE.
- ISSUE: drive bus_req=1, bus_wr, bus_addr, bus_wdata, then go to WAIT.
  - Write beat b: address base+b, data shadow[8b+7:8b].
  - Read beats 0..2: TIME_BASE+b. Read beats 3..5: DATE_BASE+(b-3).
- WAIT: hold all bus outputs stable until bus_done.
  - On bus_done with a read: capture bus_rdata into the read shadow byte.
  - If beat==beats-1, drop bus_req and go to DONE.
  - Otherwise increment beat and go to ISSUE; bus_req drops for one cycle between beats.
- DONE (one cycle):
  - Pulse the matching ack. For a poll, update time_rd and date_rd together (atomic) and pulse rd_valid.
  - Set last_was_write accordingly, return to IDLE.
  - Requests are not sampled in DONE. A requester must drop req on seeing ack, otherwise the write repeats.
- A requester dropping req before grant withdraws it. Req changes after grant are ignored.
- en falling mid-burst has no effect until IDLE.
- A reset mid-burst aborts immediately: bus_req goes low asynchronously and no ack is issued.
- bus_done outside WAIT is ignored.

Optional Feature:
- Macro: RTC_BUS_TIMEOUT_EN.
- Defined: an 8-bit watchdog counts cycles in WAIT. If it reaches TIMEOUT without bus_done:
  - abort the burst and drop bus_req;
  - pulse bus_err;
  - go to DONE without ack or rd_valid;
  - leave poll_pend set if the aborted burst was a poll.
- Undefined: WAIT blocks indefinitely, bus_err is tied to 0, and the TIMEOUT parameter is unused.

Decomposition:
- Package rtc_sched_pkg:
  - FSM state enum;
  - requester ID encoding (REQ_TIME, REQ_DATE, REQ_TIMER, REQ_POLL);
  - default base-address constants;
  - beat-count constants (3 for write, 6 for read).
- One sub-module: rtc_poll_timer, the POLL_DIV divider producing a 1-cycle tick.

Test Plan:
- Release reset with en=1 → poll burst: reads 0x21..0x23 then 0x24..0x26. With rdata 0x30,0x45,0x12,0x15,0x03,0x16: time_rd=0x124530, date_rd=0x160315, one rd_valid pulse.
- wr_time_req with 0x235959 → writes 0x21←0x59, 0x22←0x59, 0x23←0x23, one wr_time_ack, then an automatic poll burst.
- wr_date_req and wr_timer_req asserted in the same cycle → date burst first. Then the pending poll runs, because last_was_write=1. Then the timer burst, with writes to 0x41..0x43.
- Poll tick while a write burst is in progress → the poll runs right after that burst's DONE; exactly one poll, none lost or duplicated.
- Assert reset low during WAIT of beat 1 → bus_req goes low immediately, no ack; after release, a poll runs first.
- With RTC_BUS_TIMEOUT_EN and bus_done withheld → bus_err pulses at TIMEOUT cycles, no ack, FSM back to IDLE, poll retried.

Source files
------------

// File: rtl/rtc_sched_pkg.sv
// rtl/rtc_sched_pkg.sv - shared types and constants for the RTC access scheduler.
package rtc_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      REQ_TIME,
      REQ_DATE,
      REQ_TIMER,
      REQ_POLL
   } req_id_e;

   localparam logic [7:0] DEF_TIME_BASE  = 8'h21;
   localparam logic [7:0] DEF_DATE_BASE  = 8'h24;
   localparam logic [7:0] DEF_TIMER_BASE = 8'h41;

   localparam logic [2:0] BEATS_WR = 3'd3;
   localparam logic [2:0] BEATS_RD = 3'd6;

endpackage

// File: rtl/rtc_poll_timer.sv
// rtl/rtc_poll_timer.sv - free-running POLL_DIV divider, one-cycle tick at wrap.
module rtc_poll_timer #(
   parameter int unsigned POLL_DIV = 100000
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   localparam int unsigned CW = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(POLL_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/rtc_access_sched.sv
// rtl/rtc_access_sched.sv - serialises time/date/timer write bursts and read polls onto the RTC bus.
// Define RTC_BUS_TIMEOUT_EN to enable the WAIT watchdog and the bus_err pulse.
module rtc_access_sched
   import rtc_sched_pkg::*;
#(
   parameter int unsigned POLL_DIV   = 100000,
   parameter logic [7:0]  TIME_BASE  = DEF_TIME_BASE,
   parameter logic [7:0]  DATE_BASE  = DEF_DATE_BASE,
   parameter logic [7:0]  TIMER_BASE = DEF_TIMER_BASE,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        wr_time_req,
   input  logic [23:0] wr_time_data,
   output logic        wr_time_ack,
   input  logic        wr_date_req,
   input  logic [23:0] wr_date_data,
   output logic        wr_date_ack,
   input  logic        wr_timer_req,
   input  logic [23:0] wr_timer_data,
   output logic        wr_timer_ack,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [7:0]  bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic        bus_done,
   input  logic [7:0]  bus_rdata,
   output logic [23:0] time_rd,
   output logic [23:0] date_rd,
   output logic        rd_valid,
   output logic        busy,
   output logic        bus_err
);

   state_e      state_q, state_d;
   req_id_e     id_q, id_d;
   logic [23:0] shadow_q, shadow_d;
   logic [47:0] rshadow_q, rshadow_d;
   logic [2:0]  beat_q, beat_d, beats_q, beats_d;
   logic        poll_pend_q, poll_pend_d;
   logic        lww_q, lww_d;
   logic        bus_req_q, bus_req_d, bus_wr_q, bus_wr_d;
   logic [7:0]  bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
   logic [23:0] time_rd_q, time_rd_d, date_rd_q, date_rd_d;
   logic        aborted_q, aborted_d;
   logic        tick, is_wr, last_beat, pend_set, pend_clr, done_ok;
   logic [7:0]  beat_addr, beat_byte;

`ifdef RTC_BUS_TIMEOUT_EN
   logic [7:0]  wd_q, wd_d;
`else
   logic [7:0]  unused_timeout;
   assign unused_timeout = 8'(TIMEOUT);
`endif

   rtc_poll_timer #(.POLL_DIV(POLL_DIV)) u_poll_timer (
      .clk_i  (clk),
      .rst_ni (reset),
      .tick_o (tick)
   );

   assign is_wr     = (id_q != REQ_POLL);
   assign last_beat = (beat_q == beats_q - 3'd1);

   // A poll walks the three time registers, then the three date registers.
   always_comb begin
      beat_addr = 8'h00;
      beat_byte = 8'h00;
      if (is_wr) begin
         case (id_q)
            REQ_TIME: beat_addr = TIME_BASE + {5'd0, beat_q};
            REQ_DATE: beat_addr = DATE_BASE + {5'd0, beat_q};
            default:  beat_addr = TIMER_BASE + {5'd0, beat_q};
         endcase
         case (beat_q)
            3'd0:    beat_byte = shadow_q[7:0];
            3'd1:    beat_byte = shadow_q[15:8];
            default: beat_byte = shadow_q[23:16];
         endcase
      end else if (beat_q < 3'd3) begin
         beat_addr = TIME_BASE + {5'd0, beat_q};
      end else begin
         beat_addr = DATE_BASE + {5'd0, beat_q - 3'd3};
      end
   end

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      shadow_d    = shadow_q;
      rshadow_d   = rshadow_q;
      beat_d      = beat_q;
      beats_d     = beats_q;
      lww_d       = lww_q;
      bus_req_d   = bus_req_q;
      bus_wr_d    = bus_wr_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      time_rd_d   = time_rd_q;
      date_rd_d   = date_rd_q;
      aborted_d   = aborted_q;
      pend_set    = tick;
      pend_clr    = 1'b0;
`ifdef RTC_BUS_TIMEOUT_EN
      wd_d        = wd_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d   = ST_ISSUE;
               beat_d    = 3'd0;
               beats_d   = BEATS_WR;
               aborted_d = 1'b0;
               // Right after a write, a pending poll jumps the queue so the read-back is prompt.
               if (poll_pend_q && lww_q) begin
                  id_d     = REQ_POLL;
                  beats_d  = BEATS_RD;
                  pend_clr = 1'b1;
               end else if (wr_time_req) begin
                  id_d     = REQ_TIME;
                  shadow_d = wr_time_data;
               end else if (wr_date_req) begin
                  id_d     = REQ_DATE;
                  shadow_d = wr_date_data;
               end else if (wr_timer_req) begin
                  id_d     = REQ_TIMER;
                  shadow_d = wr_timer_data;
               end else if (poll_pend_q) begin
                  id_d     = REQ_POLL;
                  beats_d  = BEATS_RD;
                  pend_clr = 1'b1;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
         end
         ST_ISSUE: begin
            bus_req_d   = 1'b1;
            bus_wr_d    = is_wr;
            bus_addr_d  = beat_addr;
            bus_wdata_d = beat_byte;
            state_d     = ST_WAIT;
`ifdef RTC_BUS_TIMEOUT_EN
            wd_d        = 8'd0;
`endif
         end
         ST_WAIT: begin
            if (bus_done) begin
               bus_req_d = 1'b0;
               if (!is_wr) begin
                  rshadow_d[{beat_q, 3'b000} +: 8] = bus_rdata;
               end
               if (last_beat) begin
                  state_d = ST_DONE;
                  if (!is_wr) begin
                     time_rd_d = rshadow_q[23:0];
                     date_rd_d = {bus_rdata, rshadow_q[39:24]};
                  end
               end else begin
                  beat_d  = beat_q + 3'd1;
                  state_d = ST_ISSUE;
               end
`ifdef RTC_BUS_TIMEOUT_EN
            end else if (wd_q == 8'(TIMEOUT - 1)) begin
               bus_req_d = 1'b0;
               aborted_d = 1'b1;
               state_d   = ST_DONE;
            end else begin
               wd_d = wd_q + 8'd1;
`endif
            end
         end
         default: begin
            lww_d   = is_wr;
            state_d = ST_IDLE;
            // Completed time/date writes want a read-back; an aborted poll must be retried.
            if ((!aborted_q && (id_q == REQ_TIME || id_q == REQ_DATE)) ||
                (aborted_q && id_q == REQ_POLL)) begin
               pend_set = 1'b1;
            end
         end
      endcase
      poll_pend_d = pend_set ? 1'b1 : (pend_clr ? 1'b0 : poll_pend_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         id_q        <= REQ_TIME;
         shadow_q    <= '0;
         rshadow_q   <= '0;
         beat_q      <= '0;
         beats_q     <= BEATS_WR;
         poll_pend_q <= 1'b1;
         lww_q       <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_wr_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         time_rd_q   <= '0;
         date_rd_q   <= '0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         shadow_q    <= shadow_d;
         rshadow_q   <= rshadow_d;
         beat_q      <= beat_d;
         beats_q     <= beats_d;
         poll_pend_q <= poll_pend_d;
         lww_q       <= lww_d;
         bus_req_q   <= bus_req_d;
         bus_wr_q    <= bus_wr_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         time_rd_q   <= time_rd_d;
         date_rd_q   <= date_rd_d;
         aborted_q   <= aborted_d;
      end
   end

`ifdef RTC_BUS_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_q <= 8'd0;
      end else begin
         wd_q <= wd_d;
      end
   end
   assign bus_err = (state_q == ST_DONE) && aborted_q;
`else
   assign bus_err = 1'b0;
`endif

   assign done_ok      = (state_q == ST_DONE) && !aborted_q;
   assign wr_time_ack  = done_ok && (id_q == REQ_TIME);
   assign wr_date_ack  = done_ok && (id_q == REQ_DATE);
   assign wr_timer_ack = done_ok && (id_q == REQ_TIMER);
   assign rd_valid     = done_ok && (id_q == REQ_POLL);
   assign busy         = (state_q != ST_IDLE);
   assign bus_req      = bus_req_q;
   assign bus_wr       = bus_wr_q;
   assign bus_addr     = bus_addr_q;
   assign bus_wdata    = bus_wdata_q;
   assign time_rd      = time_rd_q;
   assign date_rd      = date_rd_q;

endmodule

// File: tb/tb_rtc_access_sched.sv
// tb/tb_rtc_access_sched.sv - directed self-checking bench for rtc_access_sched.
module tb_rtc_access_sched;

   localparam int POLL_DIV = 600;
   localparam int TIMEOUT  = 20;
   localparam int LAT      = 1;

   logic        clk = 1'b0;
   logic        reset, en;
   logic        wr_time_req, wr_date_req, wr_timer_req;
   logic [23:0] wr_time_data, wr_date_data, wr_timer_data;
   logic        wr_time_ack, wr_date_ack, wr_timer_ack;
   logic        bus_req, bus_wr, bus_done;
   logic [7:0]  bus_addr, bus_wdata, bus_rdata;
   logic [23:0] time_rd, date_rd;
   logic        rd_valid, busy, bus_err;

   int checks = 0;
   int failures = 0;
   int ack_t = 0, ack_d = 0, ack_m = 0, rv_cnt = 0, err_cnt = 0;
   logic [23:0] rv_time = '0, rv_date = '0;
   bit resp_en = 1'b1;

   logic [7:0]  mem [0:255];
   logic [16:0] log_q [$];

   always #5 clk = ~clk;

   rtc_access_sched #(
      .POLL_DIV (POLL_DIV),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .wr_time_req   (wr_time_req),
      .wr_time_data  (wr_time_data),
      .wr_time_ack   (wr_time_ack),
      .wr_date_req   (wr_date_req),
      .wr_date_data  (wr_date_data),
      .wr_date_ack   (wr_date_ack),
      .wr_timer_req  (wr_timer_req),
      .wr_timer_data (wr_timer_data),
      .wr_timer_ack  (wr_timer_ack),
      .bus_req       (bus_req),
      .bus_wr        (bus_wr),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_done      (bus_done),
      .bus_rdata     (bus_rdata),
      .time_rd       (time_rd),
      .date_rd       (date_rd),
      .rd_valid      (rd_valid),
      .busy          (busy),
      .bus_err       (bus_err)
   );

   // Bus master model: answers each request LAT+1 cycles after it appears, logs {wr,addr,data}.
   initial begin
      int cnt;
      cnt = 0;
      bus_done = 1'b0;
      bus_rdata = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h21] = 8'h30; mem[8'h22] = 8'h45; mem[8'h23] = 8'h12;
      mem[8'h24] = 8'h15; mem[8'h25] = 8'h03; mem[8'h26] = 8'h16;
      forever begin
         @(negedge clk);
         bus_done = 1'b0;
         if (bus_req === 1'b1 && resp_en) begin
            if (cnt >= LAT) begin
               bus_done = 1'b1;
               bus_rdata = mem[bus_addr];
               if (bus_wr) begin
                  mem[bus_addr] = bus_wdata;
                  log_q.push_back({1'b1, bus_addr, bus_wdata});
               end else begin
                  log_q.push_back({1'b0, bus_addr, mem[bus_addr]});
               end
               cnt = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // One clock step: observe pulses, and act as well-behaved requesters dropping req on ack.
   task automatic cycle();
      @(negedge clk);
      #1;
      if (wr_time_ack)  begin ack_t++; wr_time_req = 1'b0; end
      if (wr_date_ack)  begin ack_d++; wr_date_req = 1'b0; end
      if (wr_timer_ack) begin ack_m++; wr_timer_req = 1'b0; end
      if (rd_valid) begin rv_cnt++; rv_time = time_rd; rv_date = date_rd; end
      if (bus_err) err_cnt++;
   endtask

   task automatic wait_rv(input int budget, output bit ok);
      int r0;
      r0 = rv_cnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (rv_cnt != r0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset(input logic en_after);
      reset = 1'b0;
      repeat (3) cycle();
      en = en_after;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      int base;
      reset = 1'b0;
      en = 1'b0;
      repeat (3) cycle();
      checks++;
      if ({bus_req, bus_wr, bus_addr, bus_wdata} !== 18'h0) begin
         failures++;
         $display("FAIL reset_bus got=%h exp=0", {bus_req, bus_wr, bus_addr, bus_wdata});
      end
      checks++;
      if ({wr_time_ack, wr_date_ack, wr_timer_ack, rd_valid, busy, bus_err} !== 6'h0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000000",
                  {wr_time_ack, wr_date_ack, wr_timer_ack, rd_valid, busy, bus_err});
      end
      checks++;
      if ({time_rd, date_rd} !== 48'h0) begin
         failures++;
         $display("FAIL reset_rd got=%h exp=0", {time_rd, date_rd});
      end
      base = log_q.size();
      reset = 1'b1;
      repeat (10) cycle();
      checks++;
      if (bus_req !== 1'b0 || busy !== 1'b0 || log_q.size() != base) begin
         failures++;
         $display("FAIL en_low_gate got req=%b busy=%b beats=%0d exp 0 0 0",
                  bus_req, busy, log_q.size() - base);
      end
   endtask

   task automatic test_first_poll();
      int base, r0;
      bit ok;
      logic [16:0] exp [$];
      exp = '{{1'b0, 8'h21, 8'h30}, {1'b0, 8'h22, 8'h45}, {1'b0, 8'h23, 8'h12},
              {1'b0, 8'h24, 8'h15}, {1'b0, 8'h25, 8'h03}, {1'b0, 8'h26, 8'h16}};
      base = log_q.size();
      r0 = rv_cnt;
      en = 1'b1;
      wait_rv(100, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL poll_timeout got=no rd_valid exp=rd_valid"); end
      checks++;
      if (rv_time !== 24'h124530 || rv_date !== 24'h160315) begin
         failures++;
         $display("FAIL poll_data got=%h/%h exp=124530/160315", rv_time, rv_date);
      end
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (base + i >= log_q.size() || log_q[base + i] !== exp[i]) begin
            failures++;
            $display("FAIL poll_beat%0d got=%h exp=%h", i,
                     (base + i < log_q.size()) ? log_q[base + i] : 17'h0, exp[i]);
         end
      end
      repeat (10) cycle();
      checks++;
      if (rv_cnt - r0 != 1 || log_q.size() != base + 6) begin
         failures++;
         $display("FAIL poll_once got rv=%0d beats=%0d exp rv=1 beats=6", rv_cnt - r0, log_q.size() - base);
      end
   endtask

   task automatic test_time_write();
      int base, a0;
      bit ok;
      logic [16:0] exp [$];
      exp = '{{1'b1, 8'h21, 8'h59}, {1'b1, 8'h22, 8'h59}, {1'b1, 8'h23, 8'h23},
              {1'b0, 8'h21, 8'h59}, {1'b0, 8'h22, 8'h59}, {1'b0, 8'h23, 8'h23},
              {1'b0, 8'h24, 8'h15}, {1'b0, 8'h25, 8'h03}, {1'b0, 8'h26, 8'h16}};
      do_reset(1'b1);
      wait_rv(100, ok);
      base = log_q.size();
      a0 = ack_t;
      wr_time_data = 24'h235959;
      wr_time_req = 1'b1;
      wait_rv(200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL time_readback got=no rd_valid exp=rd_valid"); end
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (base + i >= log_q.size() || log_q[base + i] !== exp[i]) begin
            failures++;
            $display("FAIL time_beat%0d got=%h exp=%h", i,
                     (base + i < log_q.size()) ? log_q[base + i] : 17'h0, exp[i]);
         end
      end
      checks++;
      if (ack_t - a0 != 1 || rv_time !== 24'h235959) begin
         failures++;
         $display("FAIL time_ack got acks=%0d time=%h exp acks=1 time=235959", ack_t - a0, rv_time);
      end
   endtask

   task automatic test_date_timer();
      int base, t0, d0, m0, r0;
      logic [16:0] exp [$];
      exp = '{{1'b1, 8'h24, 8'h12}, {1'b1, 8'h25, 8'h07}, {1'b1, 8'h26, 8'h25},
              {1'b0, 8'h21, 8'h59}, {1'b0, 8'h22, 8'h59}, {1'b0, 8'h23, 8'h23},
              {1'b0, 8'h24, 8'h12}, {1'b0, 8'h25, 8'h07}, {1'b0, 8'h26, 8'h25},
              {1'b1, 8'h41, 8'h56}, {1'b1, 8'h42, 8'h34}, {1'b1, 8'h43, 8'h12}};
      base = log_q.size();
      t0 = ack_t; d0 = ack_d; m0 = ack_m; r0 = rv_cnt;
      wr_date_data = 24'h250712;
      wr_timer_data = 24'h123456;
      wr_date_req = 1'b1;
      wr_timer_req = 1'b1;
      for (int i = 0; i < 300 && ack_m == m0; i++) cycle();
      repeat (20) cycle();
      checks++;
      if (log_q.size() != base + exp.size()) begin
         failures++;
         $display("FAIL dt_len got=%0d exp=%0d", log_q.size() - base, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (base + i >= log_q.size() || log_q[base + i] !== exp[i]) begin
            failures++;
            $display("FAIL dt_beat%0d got=%h exp=%h", i,
                     (base + i < log_q.size()) ? log_q[base + i] : 17'h0, exp[i]);
         end
      end
      checks++;
      if (ack_d - d0 != 1 || ack_m - m0 != 1 || ack_t != t0 || rv_cnt - r0 != 1) begin
         failures++;
         $display("FAIL dt_acks got d=%0d m=%0d t=%0d rv=%0d exp 1 1 0 1",
                  ack_d - d0, ack_m - m0, ack_t - t0, rv_cnt - r0);
      end
      checks++;
      if (rv_date !== 24'h250712) begin
         failures++;
         $display("FAIL dt_date got=%h exp=250712", rv_date);
      end
   endtask

   task automatic test_tick_during_write();
      int base, m0, r0;
      logic [16:0] exp [$];
      exp = '{{1'b1, 8'h41, 8'h07}, {1'b1, 8'h42, 8'h08}, {1'b1, 8'h43, 8'h09},
              {1'b0, 8'h21, 8'h59}, {1'b0, 8'h22, 8'h59}, {1'b0, 8'h23, 8'h23},
              {1'b0, 8'h24, 8'h12}, {1'b0, 8'h25, 8'h07}, {1'b0, 8'h26, 8'h25}};
      do_reset(1'b1);
      repeat (POLL_DIV - 10) cycle();
      base = log_q.size();
      m0 = ack_m;
      r0 = rv_cnt;
      wr_timer_data = 24'h090807;
      wr_timer_req = 1'b1;
      repeat (110) cycle();
      checks++;
      if (log_q.size() != base + exp.size()) begin
         failures++;
         $display("FAIL tick_len got=%0d exp=%0d", log_q.size() - base, exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (base + i >= log_q.size() || log_q[base + i] !== exp[i]) begin
            failures++;
            $display("FAIL tick_beat%0d got=%h exp=%h", i,
                     (base + i < log_q.size()) ? log_q[base + i] : 17'h0, exp[i]);
         end
      end
      checks++;
      if (rv_cnt - r0 != 1 || ack_m - m0 != 1) begin
         failures++;
         $display("FAIL tick_once got rv=%0d ack=%0d exp rv=1 ack=1", rv_cnt - r0, ack_m - m0);
      end
   endtask

   task automatic test_reset_midburst();
      int base, t0;
      bit seen, ok;
      base = log_q.size();
      t0 = ack_t;
      seen = 1'b0;
      wr_time_data = 24'h111111;
      wr_time_req = 1'b1;
      for (int i = 0; i < 50; i++) begin
         cycle();
         if (bus_req === 1'b1 && bus_done === 1'b0 && log_q.size() == base + 1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin failures++; $display("FAIL mid_reach got=no beat1 wait exp=beat1 wait"); end
      reset = 1'b0;
      #1;
      checks++;
      if (bus_req !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_async got req=%b busy=%b exp 0 0", bus_req, busy);
      end
      wr_time_req = 1'b0;
      repeat (3) cycle();
      reset = 1'b1;
      wait_rv(100, ok);
      checks++;
      if (ack_t != t0 || !ok) begin
         failures++;
         $display("FAIL mid_ack got acks=%0d poll=%b exp acks=0 poll=1", ack_t - t0, ok);
      end
      checks++;
      if (log_q.size() != base + 7 || log_q[base] !== {1'b1, 8'h21, 8'h11} ||
          log_q[base + 1] !== {1'b0, 8'h21, 8'h11}) begin
         failures++;
         $display("FAIL mid_seq got len=%0d first=%h exp len=7 first=12111 then 02111",
                  log_q.size() - base, (log_q.size() > base) ? log_q[base] : 17'h0);
      end
   endtask

`ifdef RTC_BUS_TIMEOUT_EN
   task automatic test_timeout();
      int n, e0, r0, t0;
      bit ok;
      resp_en = 1'b0;
      do_reset(1'b1);
      e0 = err_cnt;
      r0 = rv_cnt;
      t0 = ack_t + ack_d + ack_m;
      for (int i = 0; i < 10 && bus_req !== 1'b1; i++) cycle();
      n = 0;
      for (int i = 0; i < 100 && err_cnt == e0; i++) begin
         cycle();
         n++;
      end
      checks++;
      if (err_cnt - e0 != 1 || n != TIMEOUT) begin
         failures++;
         $display("FAIL wd_err got errs=%0d cycles=%0d exp errs=1 cycles=%0d", err_cnt - e0, n, TIMEOUT);
      end
      checks++;
      if (rv_cnt != r0 || ack_t + ack_d + ack_m != t0) begin
         failures++;
         $display("FAIL wd_noack got rv=%0d acks=%0d exp 0 0", rv_cnt - r0, ack_t + ack_d + ack_m - t0);
      end
      resp_en = 1'b1;
      wait_rv(100, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL wd_retry got=no rd_valid exp=rd_valid"); end
   endtask
`endif

   initial begin
      reset = 1'b0;
      en = 1'b0;
      wr_time_req = 1'b0;  wr_date_req = 1'b0;  wr_timer_req = 1'b0;
      wr_time_data = '0;   wr_date_data = '0;   wr_timer_data = '0;
      test_reset();
      test_first_poll();
      test_time_write();
      test_date_timer();
      test_tick_during_write();
      test_reset_midburst();
`ifdef RTC_BUS_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
